sound_length_sched: RTL and testbench
=====================================

SOUND_LENGTH_SCHED -- requirements
Module: sound_length_sched

Interface
REQ-001 The block SHALL have a parameter W3 = 8: the length width for channel 3; channels 1, 2 and 4 SHALL have a fixed width of 6.
REQ-002 The block SHALL have input clk_length_ctr, 1 bit: the clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have input rst, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have input tick, 1 bit: a one-cycle length-step request (frame-sequencer strobe).
REQ-005 The block SHALL have input start, 4 bits: per-channel one-cycle trigger strobes; bit i is channel i+1.
REQ-006 The block SHALL have input single, 4 bits: per-channel length-enable (stop-on-expiry) flags, sampled when a step is performed.
REQ-007 The block SHALL have inputs len1, len2 and len4, 6 bits each: reload lengths for channels 1, 2 and 4.
REQ-008 The block SHALL have input len3, W3 bits: the reload length for channel 3.
REQ-009 The block SHALL have output enable, 4 bits, registered: per-channel sound enable.
REQ-010 The block SHALL have output busy, 1 bit, registered: high while the FSM is in SCAN.
REQ-011 The block SHALL have output tick_ovf, 1 bit, registered, sticky: set when a tick is lost.

Function
REQ-012 Shared datapath: one 8-bit counter array cnt[0..3], one incrementer and one compare; at most one channel SHALL be loaded or stepped per clock.
REQ-013 Terminal value term(i) SHALL be 63 for channels 1, 2 and 4, and 2^W3-1 for channel 3; counters SHALL count up from the loaded length to term(i).
REQ-014 Start capture: an asserted start[i] SHALL set pend[i]; a start arriving while pend[i] is already set SHALL merge (one load).
REQ-015 Load selection: each cycle, sel = lowest-index set bit of (pend | start); if sel exists, that cycle SHALL perform a LOAD of channel sel and no step.
REQ-016 LOAD: cnt[sel] <= (len==0 ? term : len), enable[sel] <= 1, pend[sel] cleared; a start[sel] in the same cycle SHALL NOT re-set pend[sel].
REQ-017 Latency: start[i] with no lower pending channel SHALL give enable[i]=1 after that same edge; each lower pending channel SHALL add one cycle.
REQ-018 FSM states: IDLE and SCAN; SCAN SHALL carry a 2-bit index idx.
REQ-019 IDLE: tick=1 SHALL go to SCAN with idx=0 on the next edge (steps begin next cycle).
REQ-020 SCAN, cycle with no LOAD: step channel idx, then idx+1; at idx=3 go to IDLE, or to SCAN idx=0 if tick_pend (clearing it).
REQ-021 SCAN, cycle with a LOAD: idx SHALL hold, and no step SHALL occur (load stalls the scan).
REQ-022 Step of channel i: if single[i]=0, no change; if single[i]=1 and cnt[i]!=term(i), cnt[i]+1; if single[i]=1 and cnt[i]==term(i), enable[i] <= 0 and cnt[i] holds.
REQ-023 Tick in SCAN (including the transition cycle): set tick_pend; if tick_pend is already set, the tick SHALL be dropped and tick_ovf <= 1.
REQ-024 Tick while the FSM leaves SCAN at idx=3 with tick_pend=0: the FSM SHALL restart SCAN idx=0 directly (no loss).
REQ-025 A channel with enable=0 SHALL still be stepped by the same rule; stepping a disabled counter at term SHALL leave enable=0.
REQ-026 busy SHALL equal (state==SCAN), registered.

Reset
REQ-027 rst=1 SHALL force, asynchronously: enable=0, cnt=0, pend=0, tick_pend=0, tick_ovf=0, state=IDLE, idx=0, busy=0.
REQ-028 Reset mid-SCAN or with pending loads SHALL discard all of them; nothing SHALL resume after reset is released.
REQ-029 The first tick or start after reset release SHALL be handled normally.

Verification
REQ-030 Start with an immediate step: start=0001, len1=62, single=0001 -> enable[0]=1 next edge; after tick, cnt0=63; after a second tick, enable[0]=0.
REQ-031 Zero-length load on channel 3: start=0100, len3=0 -> cnt2=255; the next tick with single[2]=1 -> enable[2]=0.
REQ-032 Simultaneous starts: start=1111 in one cycle -> enable bits rise 0001, 0011, 0111, 1111 on four successive edges.
REQ-033 Load during scan: tick, then start[3] two cycles later -> busy stays high one extra cycle; channel 4 gets its load and all four steps complete.
REQ-034 Tick overrun: three ticks on consecutive cycles -> one scan plus one re-scan, tick_ovf=1 and held until rst.
REQ-035 Reset mid-scan: rst asserted during idx=2 -> all outputs 0 immediately; no steps occur after release.

Source files
------------

// File: rtl/sound_length_sched.sv
// Length-counter scheduler for four sound channels. One shared 8-bit
// counter array, incrementer and comparator serve every channel. A channel
// start (load) always takes priority over a frame-sequencer step. Steps run
// as a four-cycle scan over the channels, and that scan stalls while a load
// is being taken.
module sound_length_sched #(
  parameter int unsigned W3 = 8
) (
  input  logic          clk_length_ctr,
  input  logic          rst,
  input  logic          tick,
  input  logic [3:0]    start,
  input  logic [3:0]    single,
  input  logic [5:0]    len1,
  input  logic [5:0]    len2,
  input  logic [W3-1:0] len3,
  input  logic [5:0]    len4,
  output logic [3:0]    enable,
  output logic          busy,
  output logic          tick_ovf
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [7:0] TERM6 = 8'd63;
  localparam logic [7:0] TERM3 = 8'((1 << W3) - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] cnt_q [4];
  logic [7:0] cnt_d [4];
  logic [3:0] enable_q, enable_d;
  logic [3:0] pend_q, pend_d;
  logic       tick_pend_q, tick_pend_d;
  logic       tick_ovf_q, tick_ovf_d;
  logic       busy_q;

  logic [3:0] req;
  logic       load;
  logic [1:0] sel;
  logic [7:0] load_len;
  logic [7:0] load_term;
  logic [7:0] step_term;

  // Load arbitration, shared load/step datapath and scan sequencing
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    enable_d    = enable_q;
    tick_pend_d = tick_pend_q;
    tick_ovf_d  = tick_ovf_q;
    req         = pend_q | start;
    pend_d      = req;
    load        = |req;
    sel         = '0;
    // Walk from the top down so that the lowest set bit is the one kept.
    for (int unsigned k = 0; k < 4; k++) begin
      if (req[3 - k]) sel = 2'(3 - k);
    end

    case (sel)
      2'd0:    load_len = 8'(len1);
      2'd1:    load_len = 8'(len2);
      2'd2:    load_len = 8'(len3);
      default: load_len = 8'(len4);
    endcase
    load_term = (sel == 2'd2) ? TERM3 : TERM6;
    step_term = (idx_q == 2'd2) ? TERM3 : TERM6;

    if (load) begin
      cnt_d[sel]    = (load_len == '0) ? load_term : load_len;
      enable_d[sel] = 1'b1;
      pend_d[sel]   = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        if (tick) begin
          if (tick_pend_q) tick_ovf_d  = 1'b1;
          else             tick_pend_d = 1'b1;
        end
        if (!load) begin
          if (single[idx_q]) begin
            if (cnt_q[idx_q] == step_term) enable_d[idx_q] = 1'b0;
            else                           cnt_d[idx_q]    = cnt_q[idx_q] + 8'd1;
          end
          if (idx_q == 2'd3) begin
            // A tick on the final scan cycle restarts the scan directly. It is
            // not parked in tick_pend, so it cannot be lost.
            if (tick_pend_q || tick) begin
              idx_d       = '0;
              tick_pend_d = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, with an asynchronous clear
  always_ff @(posedge clk_length_ctr or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '{default: '0};
      enable_q    <= '0;
      pend_q      <= '0;
      tick_pend_q <= 1'b0;
      tick_ovf_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      enable_q    <= enable_d;
      pend_q      <= pend_d;
      tick_pend_q <= tick_pend_d;
      tick_ovf_q  <= tick_ovf_d;
      busy_q      <= (state_d == SCAN);
    end
  end

  assign enable   = enable_q;
  assign busy     = busy_q;
  assign tick_ovf = tick_ovf_q;

endmodule

// File: tb/tb_sound_length_sched.sv
// Directed bench for sound_length_sched. Expected values are hand-derived.
module tb_sound_length_sched;

  logic       clk_length_ctr = 1'b0;
  logic       rst;
  logic       tick;
  logic [3:0] start;
  logic [3:0] single;
  logic [5:0] len1, len2, len4;
  logic [7:0] len3;
  logic [3:0] enable;
  logic       busy;
  logic       tick_ovf;

  int checks = 0;
  int errors = 0;

  sound_length_sched #(.W3(8)) dut (
    .clk_length_ctr(clk_length_ctr),
    .rst(rst),
    .tick(tick),
    .start(start),
    .single(single),
    .len1(len1),
    .len2(len2),
    .len3(len3),
    .len4(len4),
    .enable(enable),
    .busy(busy),
    .tick_ovf(tick_ovf)
  );

  always #5 clk_length_ctr = ~clk_length_ctr;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_length_ctr);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One tick from IDLE: busy for exactly four cycles, then idle again.
  task automatic run_tick(input string tag);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    chk({tag, "_busy"}, {3'b0, busy}, 4'b0001);
    cyc(4);
    chk({tag, "_idle"}, {3'b0, busy}, 4'b0000);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; start = '0; single = '0;
    len1 = '0; len2 = '0; len3 = '0; len4 = '0;
    #2;
    chk("rst_enable", enable, 4'b0000);
    chk("rst_busy", {3'b0, busy}, 4'b0000);
    chk("rst_ovf", {3'b0, tick_ovf}, 4'b0000);
    cyc(2);
    rst = 1'b0;
    cyc(1);
    chk("post_rst_enable", enable, 4'b0000);

    // Channel 1 at 62: the first step reaches 63, and the second step expires it
    single = 4'b0001; len1 = 6'd62; start = 4'b0001;
    cyc(1);
    start = '0;
    chk("ch1_load", enable, 4'b0001);
    run_tick("ch1_t1");
    chk("ch1_after_t1", enable, 4'b0001);
    run_tick("ch1_t2");
    chk("ch1_after_t2", enable, 4'b0000);
    run_tick("ch1_t3");
    chk("ch1_disabled_stays", enable, 4'b0000);

    // A zero length on channel 3 loads 255, so the next step expires it at idx 2
    single = 4'b0100; len3 = 8'd0; start = 4'b0100;
    cyc(1);
    start = '0;
    chk("ch3_load", enable, 4'b0100);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(2);
    chk("ch3_before_step", enable, 4'b0100);
    cyc(1);
    chk("ch3_expired", enable, 4'b0000);
    cyc(1);
    chk("ch3_idle", {3'b0, busy}, 4'b0000);

    // Four simultaneous starts are loaded one per cycle, lowest channel first
    single = '0; len1 = 6'd10; len2 = 6'd20; len3 = 8'd30; len4 = 6'd10;
    start = 4'b1111;
    cyc(1);
    start = '0;
    chk("multi_1", enable, 4'b0001);
    cyc(1);
    chk("multi_2", enable, 4'b0011);
    cyc(1);
    chk("multi_3", enable, 4'b0111);
    cyc(1);
    chk("multi_4", enable, 4'b1111);

    // A channel 4 load during the scan stalls it for one cycle
    single = 4'b1000; len4 = 6'd62;
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(1);
    start = 4'b1000;
    cyc(1);
    start = '0;
    cyc(2);
    chk("stall_busy_extra", {3'b0, busy}, 4'b0001);
    cyc(1);
    chk("stall_idle", {3'b0, busy}, 4'b0000);
    chk("stall_enable", enable, 4'b1111);
    run_tick("ch4_t");
    chk("ch4_expired", enable, 4'b0111);

    // A tick on the idx 3 cycle restarts the scan without an overflow
    single = '0;
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(3);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(3);
    chk("restart_busy", {3'b0, busy}, 4'b0001);
    cyc(1);
    chk("restart_idle", {3'b0, busy}, 4'b0000);
    chk("restart_no_ovf", {3'b0, tick_ovf}, 4'b0000);

    // Three consecutive ticks: one scan and one re-scan, with the third tick lost
    tick = 1'b1;
    cyc(3);
    tick = 1'b0;
    chk("ovf_set", {3'b0, tick_ovf}, 4'b0001);
    cyc(5);
    chk("rescan_busy", {3'b0, busy}, 4'b0001);
    cyc(1);
    chk("rescan_idle", {3'b0, busy}, 4'b0000);
    cyc(3);
    chk("ovf_sticky", {3'b0, tick_ovf}, 4'b0001);
    chk("enable_kept", enable, 4'b0111);

    // Reset at scan idx 2, with a pending start, clears everything immediately
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(2);
    start = 4'b0110;
    #2;
    rst = 1'b1;
    #1;
    start = '0;
    chk("mid_rst_enable", enable, 4'b0000);
    chk("mid_rst_busy", {3'b0, busy}, 4'b0000);
    chk("mid_rst_ovf", {3'b0, tick_ovf}, 4'b0000);
    cyc(2);
    rst = 1'b0;
    cyc(8);
    chk("after_rst_enable", enable, 4'b0000);
    chk("after_rst_busy", {3'b0, busy}, 4'b0000);
    chk("after_rst_ovf", {3'b0, tick_ovf}, 4'b0000);

    // The first start and tick after reset are handled normally
    start = 4'b0010;
    cyc(1);
    start = '0;
    chk("first_start", enable, 4'b0010);
    run_tick("first_tick");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
